// File: rtl/branch_predictor_pkg.sv
// ----------------------------------------------------------------------------
// branch_predictor_pkg : control-flow opcodes and direction-counter constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package branch_predictor_pkg;

  typedef enum logic [4:0] {
    OP_J   = 5'b00001,
    OP_BNE = 5'b00010,
    OP_JAL = 5'b00011,
    OP_JR  = 5'b00100,
    OP_BLT = 5'b00110
  } opcode_e;

  localparam int         CTR_BITS_DEFAULT   = 2;
  localparam logic [1:0] CTR_WEAK_TAKEN     = 2'b10;
  localparam logic [1:0] CTR_WEAK_NOT_TAKEN = 2'b01;

endpackage

`default_nettype wire

// File: rtl/branch_predictor_if.sv
// ----------------------------------------------------------------------------
// branch_predictor_if : fetch lookup and execute update bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface branch_predictor_if #(
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 32
);
  logic [PC_WIDTH-1:0]   lookup_pc;
  logic                  pred_hit;
  logic                  pred_taken;
  logic [PC_WIDTH-1:0]   pred_target;
  logic                  upd_valid;
  logic [PC_WIDTH-1:0]   upd_pc;
  logic                  upd_taken;
  logic [PC_WIDTH-1:0]   upd_target;
  logic                  upd_pred_taken;
  logic [PC_WIDTH-1:0]   upd_pred_target;
  logic                  upd_mispredict;
  logic [STAT_WIDTH-1:0] stat_hits;
  logic [STAT_WIDTH-1:0] stat_mispredicts;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_hit, pred_taken, pred_target, upd_mispredict,
           stat_hits, stat_mispredicts
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_hit, pred_taken, pred_target, upd_mispredict,
           stat_hits, stat_mispredicts
  );
endinterface

`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter : saturating up/down counter with load and clear
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  wire logic                clock,
  input  wire logic                reset,
  input  wire logic                clear,
  input  wire logic                load,
  input  wire logic                inc,
  input  wire logic                dec,
  input  wire logic [CTR_BITS-1:0] load_value,
  output logic      [CTR_BITS-1:0] count
);

  localparam logic [CTR_BITS-1:0] MAX_COUNT = '1;

  logic [CTR_BITS-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (inc && (r_count != MAX_COUNT)) begin
      r_count <= r_count + CTR_BITS'(1);
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - CTR_BITS'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor : direct-mapped BTB, saturating direction counters, optional gshare
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8,
  parameter int CTR_BITS   = CTR_BITS_DEFAULT,
  parameter int GHR_BITS   = 0,
  parameter int STAT_WIDTH = 32
) (
  input wire logic         clock,
  input wire logic         reset,
  branch_predictor_if.slave bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int GHR_W   = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CTR_BITS-1:0]   WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX   = '1;

  logic [ENTRIES-1:0]    r_valid;
  logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
  logic [PC_WIDTH-1:0]   r_target [ENTRIES];
  logic [CTR_BITS-1:0]   w_count  [ENTRIES];
  logic [GHR_W-1:0]      r_ghr;
  logic [STAT_WIDTH-1:0] r_stat_hits;
  logic [STAT_WIDTH-1:0] r_stat_mispredicts;

  logic [INDEX_BITS-1:0] w_ghr_ext;
  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic                  w_lk_hit;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0]   w_up_tag;
  logic                  w_up_hit;
  logic                  w_mispredict;

  // History register; the update in flight always hashes with the pre-shift value
  if (GHR_BITS > 0) begin : g_ghr
    logic [GHR_W:0] w_ghr_shift;
    assign w_ghr_shift = {r_ghr, bus.upd_taken};
    assign w_ghr_ext   = INDEX_BITS'(r_ghr);

    always_ff @(posedge clock) begin
      if (reset) begin
        r_ghr <= '0;
      end else if (bus.upd_valid) begin
        r_ghr <= w_ghr_shift[GHR_W-1:0];
      end
    end
  end else begin : g_bimodal
    assign r_ghr     = '0;
    assign w_ghr_ext = '0;
  end

  if (PC_WIDTH > INDEX_BITS + TAG_BITS) begin : g_pc_high
    logic w_unused_pc_high;
    assign w_unused_pc_high = ^{bus.lookup_pc[PC_WIDTH-1:INDEX_BITS+TAG_BITS],
                                bus.upd_pc[PC_WIDTH-1:INDEX_BITS+TAG_BITS]};
  end

  assign w_lk_idx = bus.lookup_pc[INDEX_BITS-1:0] ^ w_ghr_ext;
  assign w_lk_tag = bus.lookup_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign w_up_idx = bus.upd_pc[INDEX_BITS-1:0] ^ w_ghr_ext;
  assign w_up_tag = bus.upd_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  assign bus.pred_hit    = w_lk_hit;
  assign bus.pred_taken  = w_lk_hit && w_count[w_lk_idx][CTR_BITS-1];
  assign bus.pred_target = w_lk_hit ? r_target[w_lk_idx] : '0;

  assign w_mispredict = bus.upd_valid &&
                        ((bus.upd_taken != bus.upd_pred_taken) ||
                         (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
  assign bus.upd_mispredict = w_mispredict;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    logic w_sel;
    assign w_sel = bus.upd_valid && (w_up_idx == INDEX_BITS'(i));

    sat_counter #(
      .CTR_BITS (CTR_BITS)
    ) u_ctr (
      .clock      (clock),
      .reset      (reset),
      .clear      (1'b0),
      .load       (w_sel && !w_up_hit && bus.upd_taken),
      .inc        (w_sel &&  w_up_hit && bus.upd_taken),
      .dec        (w_sel &&  w_up_hit && !bus.upd_taken),
      .load_value (WEAK_TAKEN),
      .count      (w_count[i])
    );
  end

  // A taken update writes valid/tag/target whether it hit or allocates; on a
  // hit the valid and tag writes are no-ops
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (bus.upd_valid && bus.upd_taken) begin
      r_valid[w_up_idx]  <= 1'b1;
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= bus.upd_target;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_hits        <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (bus.upd_valid && bus.upd_pred_taken && (r_stat_hits != STAT_MAX)) begin
        r_stat_hits <= r_stat_hits + STAT_WIDTH'(1);
      end
      if (w_mispredict && (r_stat_mispredicts != STAT_MAX)) begin
        r_stat_mispredicts <= r_stat_mispredicts + STAT_WIDTH'(1);
      end
    end
  end

  assign bus.stat_hits        = r_stat_hits;
  assign bus.stat_mispredicts = r_stat_mispredicts;

endmodule

`default_nettype wire
